// File: rtl/fpu_lzc_pkg.sv
// Shared types and encodings for the FPU leading-one/leading-zero normaliser.
package fpu_lzc_pkg;

  // bit0 = search direction, bit1 = search polarity
  typedef struct packed {
    logic polarity;
    logic dir;
  } lzc_mode_t;

  localparam logic LZC_DIR_MSB   = 1'b0;
  localparam logic LZC_DIR_LSB   = 1'b1;
  localparam logic LZC_POL_ONES  = 1'b0;
  localparam logic LZC_POL_ZEROS = 1'b1;

endpackage

// File: rtl/fpu_lzc_tree.sv
// Combinational binary-tree first-one finder; idx is the distance of the first set
// bit from the search edge (MSB or LSB). Padded leaves never match.
module fpu_lzc_tree #(
  parameter int WIDTH    = 32,
  parameter bit FROM_LSB = 1'b0,
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  localparam int LEAVES = 1 << IDX_W;

  // Heap-ordered nodes: root at 1, leaves at LEAVES..2*LEAVES-1, leaf i is distance i.
  logic [2*LEAVES-1:1] vld;
  logic [IDX_W-1:0]    pos [1:2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < WIDTH) begin : g_real
      assign vld[LEAVES+i] = FROM_LSB ? data[i] : data[WIDTH-1-i];
    end else begin : g_pad
      assign vld[LEAVES+i] = 1'b0;
    end
    assign pos[LEAVES+i] = '0;
  end

  for (genvar l = 0; l < IDX_W; l++) begin : g_level
    for (genvar k = (LEAVES >> (l + 1)); k < (LEAVES >> l); k++) begin : g_node
      assign vld[k] = vld[2*k] | vld[2*k+1];
      assign pos[k] = vld[2*k] ? pos[2*k] : (pos[2*k+1] | (IDX_W'(1) << l));
    end
  end

  assign none = ~vld[1];
  assign idx  = vld[1] ? pos[1] : '0;

endmodule

// File: rtl/fpu_lzc_norm.sv
// Pipelined leading-one/zero detector with normalising shifter and valid/ready
// flow control; latency equals STAGES (1 or 2).
module fpu_lzc_norm
  import fpu_lzc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_mode_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_none_o,
  output logic [WIDTH-1:0] out_norm_o,
  output logic [TAG_W-1:0] out_tag_o
);

  lzc_mode_t        in_mode;
  logic [WIDTH-1:0] search_vec;
  logic [IDX_W-1:0] msb_idx, lsb_idx, c_idx;
  logic             msb_none, lsb_none, c_none;

  assign in_mode    = lzc_mode_t'(in_mode_i);
  assign search_vec = (in_mode.polarity == LZC_POL_ZEROS) ? ~in_data_i : in_data_i;

  fpu_lzc_tree #(.WIDTH(WIDTH), .FROM_LSB(1'b0)) u_tree_msb (
    .data(search_vec), .idx(msb_idx), .none(msb_none)
  );
  fpu_lzc_tree #(.WIDTH(WIDTH), .FROM_LSB(1'b1)) u_tree_lsb (
    .data(search_vec), .idx(lsb_idx), .none(lsb_none)
  );

  assign c_idx  = (in_mode.dir == LZC_DIR_LSB) ? lsb_idx  : msb_idx;
  assign c_none = (in_mode.dir == LZC_DIR_LSB) ? lsb_none : msb_none;

  // Shifts the original operand, never the inverted search vector.
  function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] d,
                                                  input logic dir, input logic none,
                                                  input logic [IDX_W-1:0] sh);
    if (none) return d;
    else if (dir == LZC_DIR_LSB) return d >> sh;
    else return d << sh;
  endfunction

  if (STAGES == 1) begin : g_one
    logic             v1;
    logic [IDX_W-1:0] r_idx;
    logic             r_none;
    logic [WIDTH-1:0] r_norm;
    logic [TAG_W-1:0] r_tag;

    assign in_ready_o = ~v1 | out_ready_i;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1     <= 1'b0;
        r_idx  <= '0;
        r_none <= 1'b0;
        r_norm <= '0;
        r_tag  <= '0;
      end else if (in_ready_o) begin
        v1 <= in_valid_i;
        if (in_valid_i) begin
          r_idx  <= c_idx;
          r_none <= c_none;
          r_norm <= norm_shift(in_data_i, in_mode.dir, c_none, c_idx);
          r_tag  <= in_tag_i;
        end
      end
    end

    assign out_valid_o = v1;
    assign out_idx_o   = r_idx;
    assign out_none_o  = r_none;
    assign out_norm_o  = r_norm;
    assign out_tag_o   = r_tag;
  end else begin : g_two
    logic             s1_v, s2_v, ready2;
    logic [IDX_W-1:0] s1_idx, s2_idx;
    logic             s1_none, s2_none, s1_dir;
    logic [WIDTH-1:0] s1_data, s2_norm;
    logic [TAG_W-1:0] s1_tag, s2_tag;

    assign ready2     = ~s2_v | out_ready_i;
    assign in_ready_o = ~s1_v | ready2;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v    <= 1'b0;
        s1_idx  <= '0;
        s1_none <= 1'b0;
        s1_data <= '0;
        s1_dir  <= 1'b0;
        s1_tag  <= '0;
        s2_v    <= 1'b0;
        s2_idx  <= '0;
        s2_none <= 1'b0;
        s2_norm <= '0;
        s2_tag  <= '0;
      end else begin
        if (in_ready_o) begin
          s1_v <= in_valid_i;
          if (in_valid_i) begin
            s1_idx  <= c_idx;
            s1_none <= c_none;
            s1_data <= in_data_i;
            s1_dir  <= in_mode.dir;
            s1_tag  <= in_tag_i;
          end
        end
        if (ready2) begin
          s2_v <= s1_v;
          if (s1_v) begin
            s2_idx  <= s1_idx;
            s2_none <= s1_none;
            s2_norm <= norm_shift(s1_data, s1_dir, s1_none, s1_idx);
            s2_tag  <= s1_tag;
          end
        end
      end
    end

    assign out_valid_o = s2_v;
    assign out_idx_o   = s2_idx;
    assign out_none_o  = s2_none;
    assign out_norm_o  = s2_norm;
    assign out_tag_o   = s2_tag;
  end

endmodule

// File: tb/tb_fpu_lzc_norm.sv
// Directed self-checking bench: 32-bit/2-stage instance plus a 24-bit/1-stage instance.
module tb_fpu_lzc_norm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, out_valid, out_ready, out_none;
  logic [31:0] in_data, out_norm;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  out_idx;

  fpu_lzc_norm #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_mode_i(in_mode), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx),
    .out_none_o(out_none), .out_norm_o(out_norm), .out_tag_o(out_tag)
  );

  // 24-bit, 1-stage instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_none;
  logic [23:0] b_in_data, b_out_norm;
  logic [1:0]  b_in_mode;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [4:0]  b_out_idx;

  fpu_lzc_norm #(.WIDTH(24), .STAGES(1), .TAG_W(4)) dut24 (
    .clk(clk), .rst(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .in_mode_i(b_in_mode), .in_tag_i(b_in_tag),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_idx_o(b_out_idx),
    .out_none_o(b_out_none), .out_norm_o(b_out_norm), .out_tag_o(b_out_tag)
  );

  // mode: bit1 = zeros, bit0 = from LSB
  localparam int NV = 9;
  logic [31:0] v_data [NV] = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_0FFF, 32'h0000_0000,
                               32'hF0F0_00FF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                               32'h0000_0000};
  logic [1:0]  v_mode [NV] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [4:0]  v_idx  [NV] = '{5'd15, 5'd16, 5'd16, 5'd0, 5'd8, 5'd0, 5'd0, 5'd31, 5'd0};
  logic        v_none [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_norm [NV] = '{32'h8000_0000, 32'h0000_0001, 32'h0FFF_0000, 32'h0000_0000,
                               32'h00F0_F000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                               32'h0000_0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_idx !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
    total++; if (out_none !== 1'b0) begin bad++; $display("FAIL reset_none got=%b exp=0", out_none); end
    total++; if (out_norm !== 32'h0) begin bad++; $display("FAIL reset_norm got=%h exp=0", out_norm); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset24_out_valid got=%b exp=0", b_out_valid); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset24_in_ready got=%b exp=1", b_in_ready); end
  endtask

  // Streams the vector table back-to-back; result k appears after k+2 edges.
  task automatic test_vectors();
    out_ready = 1'b1;
    for (int k = 0; k <= NV; k++) begin
      in_valid = (k < NV);
      if (k < NV) begin
        in_data = v_data[k];
        in_mode = v_mode[k];
        in_tag  = 4'(k + 3);
      end
      tick();
      if (k == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b exp=1", k-1, out_valid); end
        total++; if (out_idx !== v_idx[k-1]) begin bad++; $display("FAIL vec%0d_idx got=%0d exp=%0d", k-1, out_idx, v_idx[k-1]); end
        total++; if (out_none !== v_none[k-1]) begin bad++; $display("FAIL vec%0d_none got=%b exp=%b", k-1, out_none, v_none[k-1]); end
        total++; if (out_norm !== v_norm[k-1]) begin bad++; $display("FAIL vec%0d_norm got=%h exp=%h", k-1, out_norm, v_norm[k-1]); end
        total++; if (out_tag !== 4'(k + 2)) begin bad++; $display("FAIL vec%0d_tag got=%0d exp=%0d", k-1, out_tag, k+2); end
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_width24();
    logic [23:0] d [3] = '{24'h00_0001, 24'hFF_FFFF, 24'h80_0000};
    logic [1:0]  m [3] = '{2'b00, 2'b10, 2'b01};
    logic [4:0]  ei[3] = '{5'd23, 5'd0, 5'd23};
    logic        en[3] = '{1'b0, 1'b1, 1'b0};
    logic [23:0] eo[3] = '{24'h80_0000, 24'hFF_FFFF, 24'h00_0001};
    b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = d[k];
      b_in_mode  = m[k];
      b_in_tag   = 4'(k + 9);
      tick();
      total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL w24_%0d_valid got=%b exp=1", k, b_out_valid); end
      total++; if (b_out_idx !== ei[k]) begin bad++; $display("FAIL w24_%0d_idx got=%0d exp=%0d", k, b_out_idx, ei[k]); end
      total++; if (b_out_none !== en[k]) begin bad++; $display("FAIL w24_%0d_none got=%b exp=%b", k, b_out_none, en[k]); end
      total++; if (b_out_norm !== eo[k]) begin bad++; $display("FAIL w24_%0d_norm got=%h exp=%h", k, b_out_norm, eo[k]); end
      total++; if (b_out_tag !== 4'(k + 9)) begin bad++; $display("FAIL w24_%0d_tag got=%0d exp=%0d", k, b_out_tag, k+9); end
    end
    b_in_valid = 1'b0;
    tick();
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL w24_drain got=%b exp=0", b_out_valid); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcv  = 0;
    logic rdy_now;
    out_ready = 1'b0;
    in_data   = 32'h0000_0100;
    in_mode   = 2'b00;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      if (cyc == 5) out_ready = 1'b1;
      in_valid = (sent < 6);
      in_tag   = 4'(sent);
      #0;
      rdy_now = in_ready;
      if (cyc < 2) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c%0d got=%b exp=1", cyc, in_ready); end
      end else if (cyc < 5) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%b exp=0", cyc, in_ready); end
        total++; if (out_tag !== 4'd0 || out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_hold_c%0d got=%b/%0d exp=1/0", cyc, out_valid, out_tag); end
      end
      if (out_valid && out_ready) begin
        total++; if (out_tag !== 4'(rcv)) begin bad++; $display("FAIL bp_order got=%0d exp=%0d", out_tag, rcv); end
        total++; if (cyc != 5 + rcv) begin bad++; $display("FAIL bp_gap tag%0d cycle got=%0d exp=%0d", rcv, cyc, 5 + rcv); end
        rcv++;
      end
      tick();
      if (in_valid && rdy_now) sent++;
    end
    in_valid = 1'b0;
    total++; if (rcv != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", rcv); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0F00;
    in_mode   = 2'b00;
    in_tag    = 4'hA;
    tick();
    in_tag = 4'hB;
    tick();
    rst    = 1'b1;
    in_tag = 4'hC;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_fl_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_fl_ready got=%b exp=1", in_ready); end
    total++; if (out_tag !== 4'h0 || out_norm !== 32'h0) begin
      bad++; $display("FAIL rst_fl_data got=%h/%h exp=0/0", out_tag, out_norm); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_fl_stale%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_width24();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_lzc_norm.md
# fpu_lzc_norm

Pipelined, parametrised leading-one/leading-zero detector with an integrated normalising shifter for the private FPU. It accepts a WIDTH-bit operand per cycle under valid/ready flow control. It returns the first-match index, a no-match flag and the operand shifted so the found bit lands at the search edge. It sits between the adder/multiplier mantissa datapath and the rounding stage, and replaces the purely combinational first-one finder where normalisation needs pipelining and backpressure.

## Interface
- WIDTH, 32: operand width, ≥ 2, need not be a power of two.
- STAGES, 2: pipeline depth, 1 or 2; latency equals STAGES cycles.
- TAG_W, 4: width of the sideband tag carried alongside each operand.
- IDX_W, $clog2(WIDTH): derived index width; not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  operand accepted when valid & ready.
- in_data_i  in  WIDTH  operand.
- in_mode_i  in  2  bit0: 0 = search from MSB, 1 = from LSB. bit1: 0 = search for ones, 1 = search for zeros.
- in_tag_i  in  TAG_W  sideband, passed unchanged.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed when valid & ready.
- out_idx_o  out  IDX_W  match distance from the search edge.
- out_none_o  out  1  no matching bit in the operand.
- out_norm_o  out  WIDTH  normalised operand.
- out_tag_o  out  TAG_W  tag of this result.

## Operation
- Search vector: in_data_i, or ~in_data_i when mode bit1 = 1.
- MSB mode: idx = number of non-matching bits above the first match (leading count).
  - norm = data << idx (logical, zero fill).
- LSB mode: idx = position of the lowest match (trailing count).
  - norm = data >> idx (logical, zero fill).
- The shift always applies to the original in_data_i, never to the inverted vector.
- No match: none = 1, idx = 0, norm = in_data_i unchanged.
- Non-power-of-two WIDTH: padded tree leaves never match. idx ranges over 0..WIDTH-1 only.
- Each stage is a register slot with its own valid bit.
  - A slot loads when it is empty or when its contents advance in the same cycle.
  - ready_k = ~valid_k | ready_(k+1); out_ready_i terminates the chain.
- Ready paths are combinational through the chain; no skid buffer.
- Throughput is one result per cycle with no bubbles while out_ready_i = 1.
- Ordering is strictly FIFO; no result is dropped or duplicated under any ready pattern.
- out_* data holds stable while out_valid_o = 1 and out_ready_i = 0.

## Timing
- STAGES = 1: search and shift are combinational; results are registered in one slot. Latency 1.
- STAGES = 2:
  - Slot 1 registers idx, none, data, mode and tag.
  - The shift is computed from slot 1 into slot 2. Latency 2.
- Reset values:
  - all valid bits 0, so out_valid_o = 0 and in_ready_o = 1 in the first cycle after reset;
  - out_idx_o = 0, out_none_o = 0, out_norm_o = 0, out_tag_o = 0.
- Reset mid-operation: all in-flight entries are discarded. The accept cycle coincident with rst is ignored.
- Full pipeline with out_ready_i = 0: in_ready_o = 0 and no new operand is accepted.
- Simultaneous drain and fill on a full pipeline: an accept in the same cycle as an output handshake is legal and keeps occupancy constant.

## Structure
- Package fpu_lzc_pkg holds:
  - typedef lzc_mode_t (2-bit packed struct: dir, polarity);
  - localparams LZC_DIR_MSB / LZC_DIR_LSB and LZC_POL_ONES / LZC_POL_ZEROS.
- Sub-module fpu_lzc_tree:
  - combinational binary-tree first-match finder;
  - parameters WIDTH and FROM_LSB;
  - outputs idx and none.
- Top-level instantiates it twice, one per direction, and muxes on mode.dir.
- The pipeline slots and the shifter live in the top level.

## Test plan
WIDTH = 32, STAGES = 2 unless noted.
- MSB/ones, data 0x0001_0000 -> two cycles later idx = 15, none = 0, norm = 0x8000_0000.
- LSB/ones, data 0x0001_0000 -> idx = 16, none = 0, norm = 0x0000_0001.
- MSB/zeros, data 0xFFFF_0FFF -> idx = 16, norm = 0x0FFF_0000.
- MSB/ones, data 0 -> none = 1, idx = 0, norm = 0.
- WIDTH = 24, STAGES = 1, MSB/ones, data 0x00_0001 -> one cycle later idx = 23, norm = 0x80_0000.
- Backpressure: send tags 0..5 back-to-back while holding out_ready_i = 0 for 5 cycles.
  - in_ready_o drops after 2 accepts.
  - On release, tags exit in order 0..5 with no gaps, losses or duplicates.
- Reset with 2 entries in flight -> next cycle out_valid_o = 0, in_ready_o = 1, and no stale result ever appears.
